mem_bist_initiator: RTL and testbench

Initiator-side driver for the single-port memory valid/ready request interface. It runs a self-contained write-then-read-back sweep over every address, compares the read data against the expected pattern, and reports pass/fail, an error count and the first failing address. It sits in front of `memory` in place of the testbench driver, for hardware self-test and for closed-loop bring-up of the memory block.

---
 rtl/mem_bist_initiator.sv | 197 +++++++++++++++++++
 tb/tb_mem_bist_initiator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_initiator.sv
// rtl/mem_bist_initiator.sv - write/read-back memory self-test initiator on a valid/ready request port
// Optional inverted-pattern write/read phases are enabled by defining MEM_BIST_INV_PASS_EN.
module mem_bist_initiator #(
  parameter int W       = 8,
  parameter int D       = 16,
  parameter int TIMEOUT = 64,
  localparam int AW     = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  seed,
  output logic          valid,
  input  logic          ready,
  output logic          wrd,
  output logic [AW-1:0] addr,
  output logic [W-1:0]  wdata,
  input  logic [W-1:0]  rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_fail_addr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD,
`ifdef MEM_BIST_INV_PASS_EN
    S_WRI, S_RDI,
`endif
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          valid_q, valid_d, wrd_q, wrd_d;
  logic [AW-1:0] addr_q, addr_d, ff_q, ff_d;
  logic [W-1:0]  wdata_q, wdata_d, seed_q, seed_d;
  logic [15:0]   err_q, err_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, to_q, to_d;

  logic          hs, last, tmo, start_acc, inv, is_rd, mismatch;
  logic [AW-1:0] addr_nxt;
  logic [W-1:0]  exp_cur, exp_rd, exp_nxt;

  assign hs        = valid_q && ready;
  assign last      = (addr_q == AW'(D - 1));
  assign tmo       = valid_q && !ready && (wait_q == TW'(TIMEOUT - 1));
  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
  assign addr_nxt  = addr_q + AW'(1);
  assign exp_cur   = seed_q + W'(addr_q);
  assign exp_nxt   = seed_q + W'(addr_nxt);
`ifdef MEM_BIST_INV_PASS_EN
  assign inv   = (state_q == S_WRI) || (state_q == S_RDI);
  assign is_rd = (state_q == S_RD) || (state_q == S_RDI);
`else
  assign inv   = 1'b0;
  assign is_rd = (state_q == S_RD);
`endif
  assign exp_rd   = inv ? ~exp_cur : exp_cur;
  assign mismatch = hs && is_rd && (rdata != exp_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_WR;
      S_WR: begin
        if (tmo)              state_d = S_DONE;
        else if (hs && last)  state_d = S_RD;
      end
      S_RD: begin
        if (tmo)              state_d = S_DONE;
`ifdef MEM_BIST_INV_PASS_EN
        else if (hs && last)  state_d = S_WRI;
`else
        else if (hs && last)  state_d = S_DONE;
`endif
      end
`ifdef MEM_BIST_INV_PASS_EN
      S_WRI: begin
        if (tmo)              state_d = S_DONE;
        else if (hs && last)  state_d = S_RDI;
      end
      S_RDI: begin
        if (tmo)              state_d = S_DONE;
        else if (hs && last)  state_d = S_DONE;
      end
`endif
      S_DONE: if (start) state_d = S_WR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    wrd_d   = wrd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ff_d    = ff_q;
    to_d    = to_q;
    wait_d  = (valid_q && !ready) ? wait_q + TW'(1) : '0;
    // done trails the final handshake by one cycle; busy covers that gap
    done_d  = (state_q == S_DONE) && !start;
    pass_d  = done_d && (err_q == 16'd0) && !to_q;
    busy_d  = !done_d && (state_d != S_IDLE);
    if (start_acc) begin
      seed_d  = seed;
      err_d   = '0;
      ff_d    = '0;
      to_d    = 1'b0;
      valid_d = 1'b1;
      wrd_d   = 1'b1;
      addr_d  = '0;
      wdata_d = seed;
    end else if (tmo) begin
      to_d    = 1'b1;
      valid_d = 1'b0;
      wrd_d   = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end else if (hs) begin
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    ff_d  = addr_q;
      end
      if (!last) begin
        addr_d  = addr_nxt;
        wdata_d = wrd_q ? (inv ? ~exp_nxt : exp_nxt) : '0;
      end else begin
        addr_d  = '0;
        wrd_d   = 1'b0;
        wdata_d = '0;
`ifdef MEM_BIST_INV_PASS_EN
        if (state_q == S_RD) begin
          wrd_d   = 1'b1;
          wdata_d = ~seed_q;
        end
        if (state_q == S_RDI) valid_d = 1'b0;
`else
        if (state_q == S_RD) valid_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      wrd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      to_q    <= 1'b0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      wrd_q   <= wrd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      to_q    <= to_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  assign valid           = valid_q;
  assign wrd             = wrd_q;
  assign addr            = addr_q;
  assign wdata           = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = to_q;
  assign err_count       = err_q;
  assign first_fail_addr = ff_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb/tb_mem_bist_initiator.sv - table-driven scoreboard bench for mem_bist_initiator
// Honors MEM_BIST_INV_PASS_EN to expect the extra inverted phases.
module tb_mem_bist_initiator;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int TO = 64;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int NPH = 4;
`else
  localparam int NPH = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, start, valid, ready, wrd, busy, done, pass, timeout;
  logic [7:0] seed, wdata, rdata;
  logic [3:0] addr, first_fail_addr;
  logic [15:0] err_count;

  logic ready_base, stall_en, flip_en;
  int   stall_cnt = 0;
  int   hs_count  = 0;
  int   a7_cycles = 0;
  int   checks    = 0;
  int   failures  = 0;
  logic [7:0] mem [16];

  typedef struct packed {logic wr; logic [3:0] a; logic [7:0] d;} txn_t;
  txn_t sb[$];

  typedef struct {logic [7:0] s; logic flip; int err; int ff; logic ps;} vec_t;
  vec_t vt[4];

  always #5 clk = ~clk;

  mem_bist_initiator #(.W(W), .D(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .valid(valid), .ready(ready),
    .wrd(wrd), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .first_fail_addr(first_fail_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Responder, ready/rdata driver and scoreboard monitor, all on the falling edge.
  always @(negedge clk) begin
    logic blk;
    txn_t t;
    if (!stall_en) stall_cnt = 0;
    blk = stall_en && valid && wrd && (addr == 4'd7) && (stall_cnt < 3);
    if (blk) stall_cnt++;
    ready = ready_base && !blk;
    rdata = mem[addr] ^ ((flip_en && (addr == 4'd5 || addr == 4'd9)) ? 8'h01 : 8'h00);
    if (valid && wrd && addr == 4'd7 && wdata == 8'h17) a7_cycles++;
    if (!rst) sb.delete();
    else if (valid && ready) begin
      hs_count++;
      if (wrd) mem[addr] = wdata;
      if (sb.size() == 0) check("sb_underflow", 0, 1);
      else begin
        t = sb.pop_front();
        check("txn", {wrd, addr, wdata}, {t.wr, t.a, t.d});
      end
    end
  end

  task automatic push_exp(input logic [7:0] s);
    txn_t t;
    logic [7:0] e;
    for (int ph = 0; ph < NPH; ph++)
      for (int i = 0; i < D; i++) begin
        e    = s + 8'(i);
        t.wr = (ph % 2 == 0);
        t.a  = 4'(i);
        t.d  = t.wr ? ((ph < 2) ? e : ~e) : 8'h00;
        sb.push_back(t);
      end
  endtask

  task automatic run(input logic [7:0] s, input bit push, input int exp_lat, input int mid_start);
    int lat;
    if (push) push_exp(s);
    @(posedge clk); #1;
    seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_rise", valid, 1);
    check("done_clear", done, 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == mid_start);
    end
    start = 1'b0;
    check("done_latency", lat, exp_lat);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int base, a7b, n;
    rst = 1'b0; start = 1'b0; seed = 8'h00;
    ready_base = 1'b1; stall_en = 1'b0; flip_en = 1'b0;
    vt[0] = '{8'h10, 1'b0, 0,   0, 1'b1};
    vt[1] = '{8'h10, 1'b1, NPH, 5, 1'b0};
    vt[2] = '{8'hF8, 1'b0, 0,   0, 1'b1};
    vt[3] = '{8'h00, 1'b1, NPH, 5, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {valid, wrd, addr, wdata, busy, done, pass, timeout},
          {1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("rst_err", err_count, 0);
    check("rst_ff", first_fail_addr, 0);
    rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      flip_en = vt[k].flip;
      base = hs_count;
      run(vt[k].s, 1'b1, NPH * D + 1, -1);
      check("vec_err", err_count, vt[k].err);
      check("vec_ff", first_fail_addr, vt[k].ff);
      check("vec_pass", pass, vt[k].ps);
      check("vec_timeout", timeout, 0);
      check("vec_hs", hs_count - base, NPH * D);
      check("vec_sb_left", sb.size(), 0);
    end
    flip_en = 1'b0;

    // ready stalls the address-7 write for three cycles
    stall_en = 1'b1;
    base = hs_count; a7b = a7_cycles;
    run(8'h10, 1'b1, NPH * D + 4, -1);
    check("stall_a7_cycles", a7_cycles - a7b, 4);
    check("stall_hs", hs_count - base, NPH * D);
    check("stall_pass", pass, 1);
    stall_en = 1'b0;

    // a second start while busy must be ignored
    base = hs_count;
    run(8'h33, 1'b1, NPH * D + 1, 5);
    check("busy_start_hs", hs_count - base, NPH * D);
    check("busy_start_pass", pass, 1);

    ready_base = 1'b0;
    base = hs_count;
    run(8'h10, 1'b0, TO + 1, -1);
    check("to_flag", timeout, 1);
    check("to_pass", pass, 0);
    check("to_valid", valid, 0);
    check("to_err", err_count, 0);
    check("to_hs", hs_count - base, 0);
    ready_base = 1'b1;

    // asynchronous reset in the middle of the read phase
    push_exp(8'h40);
    @(posedge clk); #1;
    seed = 8'h40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(valid && !wrd && addr == 4'd4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_rd4", {valid, wrd, addr}, {1'b1, 1'b0, 4'd4});
    #1 rst = 1'b0;
    #1;
    check("async_rst_outputs", {valid, wrd, addr, wdata, busy, done, pass, timeout},
          {1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_rst_err", {err_count, first_fail_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_resume", {valid, busy, done}, 0);
    base = hs_count;
    run(8'h5A, 1'b1, NPH * D + 1, -1);
    check("post_rst_pass", pass, 1);
    check("post_rst_hs", hs_count - base, NPH * D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
